// File: rtl/bitty_sequencer.sv
// -----------------------------------------------------------------------------
// bitty_sequencer
//
// Walks an instruction memory from start_addr to end_addr (inclusive, wrapping
// modulo 2^ADDR_W) and feeds each 16-bit word to a bitty_core. For every
// address it fetches the word, launches the core with a one-cycle run pulse,
// then waits for core_done. A per-instruction watchdog halts the sequence and
// raises a sticky timeout_err if the core never completes.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : begin a program run (honoured only in IDLE/HALT)
//   start_addr/end_addr : first / last program address (inclusive)
//   mem_req/mem_addr    : instruction-memory read request and address (= pc)
//   mem_valid/mem_rdata : read data handshake and instruction word
//   instruction         : word presented to the core, held until next fetch
//   run                 : one-cycle launch pulse to the core
//   core_done           : core completion flag (honoured only in EXEC)
//   busy/halted         : status decoded from the state register
//   timeout_err         : sticky core-timeout flag, cleared by start
//   pc                  : current program address
//   inst_count          : completed instructions, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module bitty_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              core_done,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       inst_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    // The watchdog counts from 0 in the first EXEC cycle; reaching TIMEOUT-1
    // happens on the edge leaving the cycle where the count is TIMEOUT-2, so
    // the sequencer halts exactly TIMEOUT cycles after the run pulse.
    localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int              TMR_LIM  = (TIMEOUT >= 2) ? (TIMEOUT - 2) : 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_LIM);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    // Next-state and datapath update for the fetch/issue/execute sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = start_addr;
                    cnt_d   = 16'd0;
                    terr_d  = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                tmr_d   = {TMR_W{1'b0}};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (core_done) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (pc_q == end_addr) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= {ADDR_W{1'b0}};
            instr_q <= 16'h0000;
            cnt_q   <= 16'd0;
            terr_q  <= 1'b0;
            tmr_q   <= {TMR_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            tmr_q   <= tmr_d;
        end
    end

    // Handshake and status outputs come straight from the state register so
    // that no input reaches an output combinationally.
    assign mem_req     = (state_q == S_FETCH);
    assign run         = (state_q == S_ISSUE);
    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign inst_count  = cnt_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bitty_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bitty_sequencer
//
// Self-checking bench for bitty_sequencer. A memory model answers each fetch
// after a configurable delay with a word derived from the address, and a core
// model answers each run pulse with core_done after a configurable delay.
// Expected fetch addresses are queued when a program is started and popped
// on each run pulse, where pc and the presented instruction are compared.
// -----------------------------------------------------------------------------
module tb_bitty_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  end_addr;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        run;
    logic        core_done;
    logic        busy;
    logic        halted;
    logic        timeout_err;
    logic [7:0]  pc;
    logic [15:0] inst_count;

    always #5 clk = ~clk;

    bitty_sequencer #(.ADDR_W(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .run         (run),
        .core_done   (core_done),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .pc          (pc),
        .inst_count  (inst_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side model state.
    int         cyc = 0;
    int         req_cnt, exec_cnt, vdly, ddly;
    int         runs, last_run_cyc, last_valid_cyc;
    bit         in_exec, inject, inject_chk, spur, done_pend, prev_run;
    logic [7:0] cur_addr, fetch_addr;
    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rdata_of(input logic [7:0] a);
        return {~a, a};
    endfunction

    // One clock cycle: sample at the falling edge, run the memory, core and
    // scoreboard models, and drive inputs for the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        start     = 1'b0;
        mem_valid = 1'b0;
        core_done = 1'b0;
        mem_rdata = 16'h0000;
        if (prev_run) check_val("run_width", {31'd0, run}, 32'd0);
        if (done_pend) begin
            check_val("done_to_req", {31'd0, mem_req}, {31'd0, exp_q.size() != 0});
            check_val("done_to_halt", {31'd0, halted}, {31'd0, exp_q.size() == 0});
            done_pend = 1'b0;
        end
        if (run) begin
            runs++;
            last_run_cyc = cyc;
            check_val("run_latency", last_valid_cyc, cyc - 1);
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                cur_addr = exp_q.pop_front();
                check_val("run_pc", {24'd0, pc}, {24'd0, cur_addr});
                check_val("run_instr", {16'd0, instruction}, {16'd0, rdata_of(cur_addr)});
            end
            exec_cnt = 0;
            in_exec  = 1'b1;
            if (spur) core_done = 1'b1;
        end else if (in_exec) begin
            exec_cnt++;
        end
        if (inject_chk && in_exec && exec_cnt == 2) begin
            check_val("inj_busy", {31'd0, busy}, 32'd1);
            check_val("inj_mem_req", {31'd0, mem_req}, 32'd0);
            check_val("inj_pc", {24'd0, pc}, {24'd0, cur_addr});
            check_val("inj_instr", {16'd0, instruction}, {16'd0, rdata_of(cur_addr)});
            inject_chk = 1'b0;
        end
        if (inject && in_exec && exec_cnt == 1) begin
            start      = 1'b1;
            mem_valid  = 1'b1;
            mem_rdata  = 16'hDEAD;
            inject     = 1'b0;
            inject_chk = 1'b1;
        end
        if (in_exec && ddly != 0 && exec_cnt == ddly) begin
            core_done = 1'b1;
            in_exec   = 1'b0;
            done_pend = 1'b1;
        end
        if (mem_req) begin
            if (exp_q.size() > 0) check_val("fetch_addr", {24'd0, mem_addr}, {24'd0, exp_q[0]});
            if (req_cnt > 0) begin
                check_val("addr_stable", {24'd0, mem_addr}, {24'd0, fetch_addr});
            end else begin
                fetch_addr = mem_addr;
            end
            req_cnt++;
            if (req_cnt == vdly + 1) begin
                mem_valid      = 1'b1;
                mem_rdata      = rdata_of(mem_addr);
                last_valid_cyc = cyc;
            end
        end else begin
            req_cnt = 0;
        end
        prev_run = run;
    endtask

    task automatic clear_model();
        req_cnt = 0; exec_cnt = 0; runs = 0; last_run_cyc = 0; last_valid_cyc = -10;
        in_exec = 1'b0; inject = 1'b0; inject_chk = 1'b0; spur = 1'b0;
        done_pend = 1'b0; prev_run = 1'b0;
        exp_q.delete();
    endtask

    // Start a program from IDLE/HALT and check the first cycle after start.
    task automatic begin_prog(input logic [7:0] sa, input logic [7:0] ea, input int vd,
                              input int dd, input bit inj, input bit sp, input bit to);
        logic [7:0] a;
        clear_model();
        vdly = vd; ddly = dd; inject = inj; spur = sp;
        a = sa;
        for (int k = 0; k < 256; k++) begin
            exp_q.push_back(a);
            if (a == ea || to) break;
            a = a + 8'd1;
        end
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        step();
        check_val("start_busy", {31'd0, busy}, 32'd1);
        check_val("start_mem_req", {31'd0, mem_req}, 32'd1);
        check_val("start_pc", {24'd0, pc}, {24'd0, sa});
        check_val("start_count", {16'd0, inst_count}, 32'd0);
        check_val("start_terr", {31'd0, timeout_err}, 32'd0);
        check_val("start_halted", {31'd0, halted}, 32'd0);
    endtask

    task automatic run_program(input logic [7:0] sa, input logic [7:0] ea, input int vd,
                               input int dd, input bit inj, input bit sp,
                               input int exp_n, input bit to);
        int guard;
        begin_prog(sa, ea, vd, dd, inj, sp, to);
        guard = 0;
        while (!halted && guard < 3000) begin
            step();
            guard++;
        end
        check_val("halt_reached", {31'd0, halted}, 32'd1);
        check_val("halt_pc", {24'd0, pc}, to ? {24'd0, sa} : {24'd0, ea});
        check_val("halt_count", {16'd0, inst_count}, exp_n);
        check_val("halt_terr", {31'd0, timeout_err}, {31'd0, to});
        check_val("halt_runs", runs, to ? 1 : exp_n);
        check_val("halt_busy", {31'd0, busy}, 32'd0);
        check_val("sb_left", exp_q.size(), 32'd0);
        if (to) check_val("timeout_cycles", cyc - last_run_cyc, 64);
        // HALT must hold even with stray handshakes.
        for (int k = 0; k < 3; k++) begin
            step();
            mem_valid = 1'b1;
            core_done = 1'b1;
        end
        step();
        check_val("hold_halted", {31'd0, halted}, 32'd1);
        check_val("hold_pc", {24'd0, pc}, to ? {24'd0, sa} : {24'd0, ea});
        check_val("hold_count", {16'd0, inst_count}, exp_n);
        check_val("hold_terr", {31'd0, timeout_err}, {31'd0, to});
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check_val({tag, "_run"}, {31'd0, run}, 32'd0);
        check_val({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check_val({tag, "_pc"}, {24'd0, pc}, 32'd0);
        check_val({tag, "_instr"}, {16'd0, instruction}, 32'd0);
        check_val({tag, "_count"}, {16'd0, inst_count}, 32'd0);
        check_val({tag, "_terr"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; start_addr = 8'd0; end_addr = 8'd0;
        mem_valid = 1'b0; mem_rdata = 16'h0000; core_done = 1'b0;
        clear_model();
        vdly = 1; ddly = 1;
        repeat (3) step();
        check_reset_state("rst");
        reset = 1'b0;
        step();

        // Basic three-instruction program.
        run_program(8'd3, 8'd5, 1, 4, 1'b0, 1'b0, 3, 1'b0);
        // Slow memory: request held for eight cycles per fetch.
        run_program(8'd20, 8'd21, 7, 3, 1'b0, 1'b0, 2, 1'b0);
        // Address wrap.
        run_program(8'hFE, 8'h01, 1, 2, 1'b0, 1'b0, 4, 1'b0);
        // Single instruction with stray start/mem_valid in EXEC and done in ISSUE.
        run_program(8'd7, 8'd7, 2, 5, 1'b1, 1'b1, 1, 1'b0);
        // Core never completes.
        run_program(8'd30, 8'd35, 1, 0, 1'b0, 1'b0, 0, 1'b1);
        // Restart after timeout clears the flag; zero-latency memory.
        run_program(8'd0, 8'd2, 0, 1, 1'b0, 1'b0, 3, 1'b0);

        // Reset in EXEC of the second instruction, together with done and start.
        begin_prog(8'd10, 8'd20, 1, 10, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (!(runs == 2 && in_exec && exec_cnt == 3) && guard < 200) begin
            step();
            guard++;
        end
        check_val("pre_reset_count", {16'd0, inst_count}, 32'd1);
        reset     = 1'b1;
        core_done = 1'b1;
        start     = 1'b1;
        step();
        check_reset_state("mid_rst");
        reset = 1'b0;
        clear_model();
        step();
        check_val("idle_after_rst", {31'd0, busy}, 32'd0);

        // Normal operation resumes after the mid-program reset.
        run_program(8'd40, 8'd41, 1, 1, 1'b0, 1'b0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
